// File: rtl/fft8_sched.sv
// fft8_sched: 8-point radix-2 DIT FFT scheduler. Loads eight complex samples
// in bit-reversed order, drives an external one-cycle butterfly through three
// stages (each halving, overall scale 1/8), then streams the eight bins out.
module fft8_sched #(
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_re,
   input  logic signed [DATA_W-1:0] in_im,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_re,
   output logic signed [DATA_W-1:0] out_im,
   output logic [2:0]               out_idx,
   output logic                     busy,
   output logic                     bf_in_en,
   output logic [1:0]               bf_rotate,
   output logic signed [DATA_W-1:0] bf_a_re,
   output logic signed [DATA_W-1:0] bf_a_im,
   output logic signed [DATA_W-1:0] bf_b_re,
   output logic signed [DATA_W-1:0] bf_b_im,
   input  logic signed [DATA_W-1:0] bf_c_re,
   input  logic signed [DATA_W-1:0] bf_c_im,
   input  logic signed [DATA_W-1:0] bf_d_re,
   input  logic signed [DATA_W-1:0] bf_d_im,
   input  logic                     bf_out_en
);

   typedef enum logic [1:0] {LOAD, CALC, OUT} state_t;

   state_t      state, state_nx;
   logic [2:0]  in_cnt, in_cnt_nx;
   logic [1:0]  stage, stage_nx;
   logic [2:0]  iss, iss_nx;
   logic [2:0]  out_cnt, out_cnt_nx;
   logic [2:0]  p_p1, p_p1_nx;
   logic [2:0]  q_p1, q_p1_nx;
   logic        vld_p1, vld_p1_nx;

   logic [2:0]  pa, qa;
   logic [1:0]  rot;
   logic        issue;
   logic        load_wr;
   logic        res_wr;

   logic signed [DATA_W-1:0] mem_re [8];
   logic signed [DATA_W-1:0] mem_im [8];

   function automatic logic [2:0] bitrev3(input logic [2:0] n);
      return {n[0], n[1], n[2]};
   endfunction

   // Butterfly pair and twiddle for issue slot iss within the current stage
   always_comb begin
      pa  = {iss[1:0], 1'b0};
      qa  = {iss[1:0], 1'b1};
      rot = 2'd0;
      case (stage)
         2'd2: begin
            pa  = {iss[1], 1'b0, iss[0]};
            qa  = {iss[1], 1'b1, iss[0]};
            rot = {iss[0], 1'b0};
         end
         2'd3: begin
            pa  = {1'b0, iss[1:0]};
            qa  = {1'b1, iss[1:0]};
            rot = iss[1:0];
         end
         default: ;
      endcase
   end

   assign issue     = (state == CALC) && (iss != 3'd4);
   assign load_wr   = (state == LOAD) && in_valid;
   assign res_wr    = (state == CALC) && vld_p1 && bf_out_en;

   assign in_ready  = (state == LOAD);
   assign busy      = (state != LOAD);
   assign out_valid = (state == OUT);
   assign out_idx   = out_cnt;
   assign out_re    = mem_re[out_cnt];
   assign out_im    = mem_im[out_cnt];

   assign bf_in_en  = issue;
   assign bf_rotate = issue ? rot : 2'd0;
   assign bf_a_re   = mem_re[pa];
   assign bf_a_im   = mem_im[pa];
   assign bf_b_re   = mem_re[qa];
   assign bf_b_im   = mem_im[qa];

   // Next-state logic: load count, stage/issue sequencing, output count
   always_comb begin
      state_nx   = state;
      in_cnt_nx  = in_cnt;
      stage_nx   = stage;
      iss_nx     = iss;
      out_cnt_nx = out_cnt;
      p_p1_nx    = p_p1;
      q_p1_nx    = q_p1;
      vld_p1_nx  = 1'b0;
      case (state)
         LOAD: begin
            if (in_valid) begin
               in_cnt_nx = in_cnt + 3'd1;
               if (in_cnt == 3'd7) begin
                  state_nx  = CALC;
                  in_cnt_nx = 3'd0;
                  stage_nx  = 2'd1;
                  iss_nx    = 3'd0;
               end
            end
         end
         CALC: begin
            if (issue) begin
               vld_p1_nx = 1'b1;
               p_p1_nx   = pa;
               q_p1_nx   = qa;
            end
            if (iss == 3'd4) begin
               iss_nx = 3'd0;
               if (stage == 2'd3) begin
                  stage_nx = 2'd0;
                  state_nx = OUT;
               end else begin
                  stage_nx = stage + 2'd1;
               end
            end else begin
               iss_nx = iss + 3'd1;
            end
         end
         OUT: begin
            if (out_ready) begin
               out_cnt_nx = out_cnt + 3'd1;
               if (out_cnt == 3'd7) begin
                  state_nx   = LOAD;
                  out_cnt_nx = 3'd0;
               end
            end
         end
         default: state_nx = LOAD;
      endcase
   end

   // Control registers; reset aborts any frame and drops pending results
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= LOAD;
         in_cnt  <= 3'd0;
         stage   <= 2'd0;
         iss     <= 3'd0;
         out_cnt <= 3'd0;
         p_p1    <= 3'd0;
         q_p1    <= 3'd0;
         vld_p1  <= 1'b0;
      end else begin
         state   <= state_nx;
         in_cnt  <= in_cnt_nx;
         stage   <= stage_nx;
         iss     <= iss_nx;
         out_cnt <= out_cnt_nx;
         p_p1    <= p_p1_nx;
         q_p1    <= q_p1_nx;
         vld_p1  <= vld_p1_nx;
      end
   end

   // Sample buffer: bit-reversed loads and in-place butterfly write-back
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (load_wr) begin
            mem_re[bitrev3(in_cnt)] <= in_re;
            mem_im[bitrev3(in_cnt)] <= in_im;
         end
         if (res_wr) begin
            mem_re[p_p1] <= bf_c_re;
            mem_im[p_p1] <= bf_c_im;
            mem_re[q_p1] <= bf_d_re;
            mem_im[q_p1] <= bf_d_im;
         end
      end
   end

endmodule

// File: tb/tb_fft8_sched.sv
// Directed bench for fft8_sched with a behavioural Q16 butterfly.
module tb_fft8_sched;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic signed [31:0] in_re, in_im;
   logic               out_valid;
   logic               out_ready;
   logic signed [31:0] out_re, out_im;
   logic [2:0]         out_idx;
   logic               busy;
   logic               bf_in_en;
   logic [1:0]         bf_rotate;
   logic signed [31:0] bf_a_re, bf_a_im, bf_b_re, bf_b_im;
   logic signed [31:0] bf_c_re, bf_c_im, bf_d_re, bf_d_im;
   logic               bf_out_en;
   logic               bfm_en;
   logic               stray;

   int n_assert = 0;
   int n_fail   = 0;

   int xr [8];
   int xi [8];
   int er [8];
   int ei [8];

   always #5 clk = ~clk;

   fft8_sched dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
      .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
      .out_idx(out_idx), .busy(busy),
      .bf_in_en(bf_in_en), .bf_rotate(bf_rotate),
      .bf_a_re(bf_a_re), .bf_a_im(bf_a_im), .bf_b_re(bf_b_re), .bf_b_im(bf_b_im),
      .bf_c_re(bf_c_re), .bf_c_im(bf_c_im), .bf_d_re(bf_d_re), .bf_d_im(bf_d_im),
      .bf_out_en(bf_out_en)
   );

   // Behavioural butterfly: c=(a+W8^k*b)/2, d=(a-W8^k*b)/2, Q16, one-cycle latency
   function automatic longint tw_re(input logic [1:0] k);
      case (k)
         2'd0: return 65536;
         2'd1: return 46341;
         2'd2: return 0;
         default: return -46341;
      endcase
   endfunction

   function automatic longint tw_im(input logic [1:0] k);
      case (k)
         2'd0: return 0;
         2'd1: return -46341;
         2'd2: return -65536;
         default: return -46341;
      endcase
   endfunction

   longint t_re, t_im;
   assign t_re = (tw_re(bf_rotate) * longint'(bf_b_re) - tw_im(bf_rotate) * longint'(bf_b_im)) >>> 16;
   assign t_im = (tw_re(bf_rotate) * longint'(bf_b_im) + tw_im(bf_rotate) * longint'(bf_b_re)) >>> 16;

   // Register butterfly results one cycle after issue
   always_ff @(posedge clk) begin
      bfm_en  <= bf_in_en;
      bf_c_re <= 32'((longint'(bf_a_re) + t_re) >>> 1);
      bf_c_im <= 32'((longint'(bf_a_im) + t_im) >>> 1);
      bf_d_re <= 32'((longint'(bf_a_re) - t_re) >>> 1);
      bf_d_im <= 32'((longint'(bf_a_im) - t_im) >>> 1);
   end

   assign bf_out_en = bfm_en | stray;

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic clear_vec();
      for (int i = 0; i < 8; i++) begin
         xr[i] = 0; xi[i] = 0; er[i] = 0; ei[i] = 0;
      end
   endtask

   // Load a frame, check CALC timing, then read out with optional stall/abort
   task automatic run_frame(input int hold, input int bp_k, input int abort_c);
      int pulses;
      int s, j, exp_en, exp_rot;
      pulses = 0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         chk($sformatf("in_ready load n=%0d", n), in_ready, 1);
         in_valid = 1'b1;
         in_re    = xr[n];
         in_im    = xi[n];
      end
      @(negedge clk);
      if (hold != 0) begin
         in_re = 32'sd777777;
         in_im = -32'sd555555;
      end else begin
         in_valid = 1'b0;
      end
      for (int c = 0; c < 15; c++) begin
         if (c == abort_c) begin
            rst = 1'b1;
            #1;
            chk("abort in_ready", in_ready, 1);
            chk("abort bf_in_en", bf_in_en, 0);
            chk("abort busy", busy, 0);
            chk("abort bf_rotate", bf_rotate, 0);
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            in_valid = 1'b0;
            @(negedge clk);
            chk("post-abort in_ready", in_ready, 1);
            chk("post-abort out_valid", out_valid, 0);
            chk("post-abort bf_in_en", bf_in_en, 0);
            return;
         end
         s = c / 5 + 1;
         j = c % 5;
         exp_en = (j != 4) ? 1 : 0;
         if (exp_en == 0 || s == 1) exp_rot = 0;
         else if (s == 2) exp_rot = (j % 2) * 2;
         else exp_rot = j;
         chk($sformatf("bf_in_en c=%0d", c), bf_in_en, exp_en);
         chk($sformatf("bf_rotate c=%0d", c), bf_rotate, exp_rot);
         chk($sformatf("busy c=%0d", c), busy, 1);
         chk($sformatf("out_valid c=%0d", c), out_valid, 0);
         chk($sformatf("in_ready c=%0d", c), in_ready, 0);
         if (bf_in_en) pulses++;
         @(negedge clk);
      end
      chk("bf_in_en pulses", pulses, 12);
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (k == bp_k) begin
            out_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
               stray = (i == 1);
               chk($sformatf("stall out_idx i=%0d", i), out_idx, k);
               chk($sformatf("stall out_re i=%0d", i), out_re, er[k]);
               chk($sformatf("stall out_im i=%0d", i), out_im, ei[k]);
               chk($sformatf("stall in_ready i=%0d", i), in_ready, 0);
               @(negedge clk);
            end
            stray = 1'b0;
            out_ready = 1'b1;
         end
         chk($sformatf("out_valid k=%0d", k), out_valid, 1);
         chk($sformatf("out_idx k=%0d", k), out_idx, k);
         chk($sformatf("out_re k=%0d", k), out_re, er[k]);
         chk($sformatf("out_im k=%0d", k), out_im, ei[k]);
         chk($sformatf("in_ready out k=%0d", k), in_ready, 0);
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("end in_ready", in_ready, 1);
      chk("end out_valid", out_valid, 0);
      chk("end busy", busy, 0);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_re     = '0;
      in_im     = '0;
      out_ready = 1'b1;
      stray     = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst in_ready", in_ready, 1);
      chk("rst out_valid", out_valid, 0);
      chk("rst busy", busy, 0);
      chk("rst bf_in_en", bf_in_en, 0);
      chk("rst bf_rotate", bf_rotate, 0);
      chk("rst out_idx", out_idx, 0);
      @(negedge clk);
      rst = 1'b0;

      // Impulse at x[0]: every bin 8192
      clear_vec();
      xr[0] = 65536;
      for (int i = 0; i < 8; i++) er[i] = 8192;
      run_frame(0, -1, -1);

      // DC: bin 0 = 65536, others 0
      clear_vec();
      for (int i = 0; i < 8; i++) xr[i] = 65536;
      er[0] = 65536;
      run_frame(0, -1, -1);

      // Impulse at x[4]: alternating +/-8192, stall at k=3 with a stray bf_out_en
      clear_vec();
      xr[4] = 65536;
      for (int i = 0; i < 8; i++) er[i] = (i % 2 == 0) ? 8192 : -8192;
      run_frame(0, 3, -1);

      // Impulse at x[2]: 8192*(-j)^k, in_valid held during CALC/OUT
      clear_vec();
      xr[2] = 65536;
      er[0] = 8192;  ei[1] = -8192; er[2] = -8192; ei[3] = 8192;
      er[4] = 8192;  ei[5] = -8192; er[6] = -8192; ei[7] = 8192;
      run_frame(1, -1, -1);

      // Abort at stage 2, j=1, then a clean impulse frame
      clear_vec();
      for (int i = 0; i < 8; i++) xr[i] = 1000 * (i + 1);
      run_frame(0, -1, 6);
      clear_vec();
      xr[0] = 65536;
      for (int i = 0; i < 8; i++) er[i] = 8192;
      run_frame(0, -1, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
